pc_sequencer: RTL and testbench

Next-PC controller for the 5-stage RISC-V core: it drives the `next_pc` input of the program counter register, which loads every cycle. It chooses among sequential fetch, hold, and redirect (trap, EX-stage branch, ID-stage jump). It also sequences the instruction-memory fetch handshake, including redirects that arrive while a fetch is outstanding, and generates the IF/ID flush signals.

---
 rtl/pc_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// ============================================================================
// pc_sequencer
// ----------------------------------------------------------------------------
// Next-PC controller for the 5-stage RISC-V core. It drives the next_pc input
// of the external program counter register, which loads every cycle, and
// chooses among sequential fetch, hold and redirect (trap, EX-stage branch,
// ID-stage jump). It also sequences the instruction-memory fetch handshake,
// parks a redirect that arrives while a fetch is outstanding, and generates
// the IF/ID and ID/EX flush strobes.
//
// Parameters
//   RESET_VECTOR      first fetch address after reset
//   TRAP_VECTOR       redirect target on trap_req
//
// Ports
//   clk               clock, rising edge
//   reset             asynchronous, active-high reset
//   pc                current PC (also the instruction-memory address)
//   next_pc           value loaded into the PC register at the next edge
//   imem_req          fetch request for address pc
//   imem_ready        instruction for pc returned this cycle
//   fetch_valid       returned instruction is on the correct path
//   stall_id          load-use hold from ID
//   jump_id           JAL/JALR resolved in ID (pulse), target jump_target_id
//   branch_taken_ex   taken branch resolved in EX (pulse), target branch_target_ex
//   trap_req          trap / exception request (pulse)
//   flush_if          squash the IF/ID register
//   flush_id          squash the ID/EX register
//   hold_count        cycles in which next_pc == pc (wrapping)
//   redirect_count    accepted redirect events (saturating)
//
// next_pc, imem_req, fetch_valid and the flushes are combinational from state
// and inputs; state, the pending target and both counters are registered.
// ============================================================================
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] next_pc,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        fetch_valid,
    input  logic        stall_id,
    input  logic        jump_id,
    input  logic [31:0] jump_target_id,
    input  logic        branch_taken_ex,
    input  logic [31:0] branch_target_ex,
    input  logic        trap_req,
    output logic        flush_if,
    output logic        flush_id,
    output logic [31:0] hold_count,
    output logic [15:0] redirect_count
);

    localparam int unsigned XLEN    = 32;
    localparam int unsigned RCNT_W  = 16;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [XLEN-1:0]     pending_q, pending_d;
    logic [XLEN-1:0]     hold_count_q, hold_count_d;
    logic [RCNT_W-1:0]   redirect_count_q, redirect_count_d;

    // Redirect decode
    logic                redir_valid;
    logic                redir_hard;      // trap or branch: flush both stages
    logic [XLEN-1:0]     redir_raw;
    logic [XLEN-1:0]     redir_target;

    // Prioritised redirect select: trap > branch > unstalled jump
    always_comb begin
        redir_valid = 1'b0;
        redir_hard  = 1'b0;
        redir_raw   = '0;
        if (trap_req) begin
            redir_valid = 1'b1;
            redir_hard  = 1'b1;
            redir_raw   = TRAP_VECTOR;
        end else if (branch_taken_ex) begin
            redir_valid = 1'b1;
            redir_hard  = 1'b1;
            redir_raw   = branch_target_ex;
        end else if (jump_id && !stall_id) begin
            redir_valid = 1'b1;
            redir_raw   = jump_target_id;
        end
    end

    // Targets are always word aligned
    assign redir_target = redir_raw & ALIGN_MASK;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= BOOT;
            pending_q        <= '0;
            hold_count_q     <= '0;
            redirect_count_q <= '0;
        end else begin
            state_q          <= state_d;
            pending_q        <= pending_d;
            hold_count_q     <= hold_count_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    // Next-state and fetch/flush outputs
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        next_pc     = pc;
        imem_req    = 1'b0;
        fetch_valid = 1'b0;
        flush_if    = 1'b0;
        flush_id    = 1'b0;

        unique case (state_q)
            BOOT: begin
                // Inputs are ignored; reset state also lands here, so the
                // combinational outputs take their reset values immediately.
                next_pc = RESET_VECTOR;
                state_d = RUN;
            end

            RUN: begin
                imem_req = 1'b1;
                if (redir_valid) begin
                    flush_if = 1'b1;
                    flush_id = redir_hard;
                    if (imem_ready) begin
                        next_pc = redir_target;
                    end else begin
                        // Outstanding access must complete; park the target
                        pending_d = redir_target;
                        state_d   = DRAIN;
                    end
                end else if (imem_ready && !stall_id) begin
                    next_pc     = pc + PC_STEP;
                    fetch_valid = 1'b1;
                end
            end

            DRAIN: begin
                imem_req = 1'b1;
                if (redir_valid) begin
                    // Newest event wins
                    flush_if  = 1'b1;
                    flush_id  = redir_hard;
                    pending_d = redir_target;
                end
                if (imem_ready) begin
                    next_pc = redir_valid ? redir_target : pending_q;
                    state_d = RUN;
                end
            end

            default: begin
                next_pc = RESET_VECTOR;
                state_d = BOOT;
            end
        endcase
    end

    // Performance counters
    always_comb begin
        hold_count_d     = hold_count_q;
        redirect_count_d = redirect_count_q;
        if (state_q != BOOT) begin
            if (next_pc == pc) begin
                hold_count_d = hold_count_q + 32'd1;
            end
            if (redir_valid && (redirect_count_q != {RCNT_W{1'b1}})) begin
                redirect_count_d = redirect_count_q + 16'd1;
            end
        end
    end

    assign hold_count     = hold_count_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer. The bench owns the PC register
// (loads next_pc every edge, with an override used to jump to test addresses).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        imem_req;
    logic        imem_ready;
    logic        fetch_valid;
    logic        stall_id;
    logic        jump_id;
    logic [31:0] jump_target_id;
    logic        branch_taken_ex;
    logic [31:0] branch_target_ex;
    logic        trap_req;
    logic        flush_if;
    logic        flush_id;
    logic [31:0] hold_count;
    logic [15:0] redirect_count;

    logic        pc_load;
    logic [31:0] pc_load_val;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          id;
        logic        rst, rdy, stl, jmp, br, trp;
        logic [31:0] jt, bt;
        logic [31:0] e_pc, e_npc;
        logic        e_req, e_fv, e_fi, e_fd;
        logic        chk_cnt;
        logic [31:0] e_hold;
        logic [15:0] e_redir;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .pc               (pc),
        .next_pc          (next_pc),
        .imem_req         (imem_req),
        .imem_ready       (imem_ready),
        .fetch_valid      (fetch_valid),
        .stall_id         (stall_id),
        .jump_id          (jump_id),
        .jump_target_id   (jump_target_id),
        .branch_taken_ex  (branch_taken_ex),
        .branch_target_ex (branch_target_ex),
        .trap_req         (trap_req),
        .flush_if         (flush_if),
        .flush_id         (flush_id),
        .hold_count       (hold_count),
        .redirect_count   (redirect_count)
    );

    always #5 clk = ~clk;

    // External PC register
    always @(posedge clk or posedge reset) begin
        if (reset)        pc <= 32'h0000_0000;
        else if (pc_load) pc <= pc_load_val;
        else              pc <= next_pc;
    end

    task automatic chk(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %h, required %h", name, id, act, exp);
        end
    endtask

    // Scoreboard: compare outputs mid-cycle against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t v;
            v = exp_q.pop_front();
            chk("pc",          v.id, pc,                  v.e_pc);
            chk("next_pc",     v.id, next_pc,             v.e_npc);
            chk("imem_req",    v.id, 32'(imem_req),       32'(v.e_req));
            chk("fetch_valid", v.id, 32'(fetch_valid),    32'(v.e_fv));
            chk("flush_if",    v.id, 32'(flush_if),       32'(v.e_fi));
            chk("flush_id",    v.id, 32'(flush_id),       32'(v.e_fd));
            if (v.chk_cnt) begin
                chk("hold_count",     v.id, hold_count,          v.e_hold);
                chk("redirect_count", v.id, 32'(redirect_count), 32'(v.e_redir));
            end
        end
    end

    function automatic vec_t mk(input int id,
                                input logic rst, rdy, stl, jmp, br, trp,
                                input logic [31:0] jt, bt, e_pc, e_npc,
                                input logic e_req, e_fv, e_fi, e_fd);
        vec_t v;
        v.id = id; v.rst = rst; v.rdy = rdy; v.stl = stl;
        v.jmp = jmp; v.br = br; v.trp = trp; v.jt = jt; v.bt = bt;
        v.e_pc = e_pc; v.e_npc = e_npc;
        v.e_req = e_req; v.e_fv = e_fv; v.e_fi = e_fi; v.e_fd = e_fd;
        v.chk_cnt = 1'b0; v.e_hold = '0; v.e_redir = '0;
        return v;
    endfunction

    function automatic vec_t cnt(input vec_t vin, input logic [31:0] h, input logic [15:0] r);
        vec_t v;
        v = vin;
        v.chk_cnt = 1'b1; v.e_hold = h; v.e_redir = r;
        return v;
    endfunction

    // Drive one cycle of stimulus and queue its expectation
    task automatic apply(input vec_t v);
        reset            = v.rst;
        imem_ready       = v.rdy;
        stall_id         = v.stl;
        jump_id          = v.jmp;
        branch_taken_ex  = v.br;
        trap_req         = v.trp;
        jump_target_id   = v.jt;
        branch_target_ex = v.bt;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
    endtask

    // Overwrite the PC register for one edge (DUT in RUN, plain fetch)
    task automatic load_pc(input logic [31:0] val);
        reset = 1'b0; imem_ready = 1'b1; stall_id = 1'b0; jump_id = 1'b0;
        branch_taken_ex = 1'b0; trap_req = 1'b0;
        pc_load = 1'b1; pc_load_val = val;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    initial begin
        pc_load = 1'b0; pc_load_val = '0;
        imem_ready = 1'b0; stall_id = 1'b0; jump_id = 1'b0; branch_taken_ex = 1'b0;
        trap_req = 1'b0; jump_target_id = '0; branch_target_ex = '0;
        @(posedge clk);
        #1;

        //             id rst rdy stl jmp br trp  jt            bt            pc            next_pc      req fv fi fd
        tbl.push_back(mk( 0,1,1,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h0,        0,0,0,0));
        tbl.push_back(cnt(mk( 1,1,1,0,1,1,1, 32'h500, 32'h200,       32'h0,        32'h0,        0,0,0,0), 32'd0, 16'd0));
        tbl.push_back(mk( 2,0,1,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h0,        0,0,0,0));
        tbl.push_back(mk( 3,0,1,0,0,0,0, 32'h0,        32'h0,        32'h0,        32'h4,        1,1,0,0));
        tbl.push_back(mk( 4,0,1,0,0,0,0, 32'h0,        32'h0,        32'h4,        32'h8,        1,1,0,0));
        tbl.push_back(mk( 5,0,1,0,0,0,0, 32'h0,        32'h0,        32'h8,        32'hC,        1,1,0,0));
        tbl.push_back(mk( 6,0,0,0,0,0,0, 32'h0,        32'h0,        32'hC,        32'hC,        1,0,0,0));
        tbl.push_back(mk( 7,0,1,1,0,0,0, 32'h0,        32'h0,        32'hC,        32'hC,        1,0,0,0));
        tbl.push_back(mk( 8,0,1,1,1,0,0, 32'h500,      32'h0,        32'hC,        32'hC,        1,0,0,0));
        tbl.push_back(mk( 9,0,1,1,0,1,0, 32'h0,        32'h203,      32'hC,        32'h200,      1,0,1,1));
        tbl.push_back(mk(10,0,1,0,0,0,0, 32'h0,        32'h0,        32'h200,      32'h204,      1,1,0,0));
        tbl.push_back(mk(11,0,1,0,1,1,0, 32'h300,      32'h200,      32'h204,      32'h200,      1,0,1,1));
        tbl.push_back(mk(12,0,1,0,1,0,0, 32'h301,      32'h0,        32'h200,      32'h300,      1,0,1,0));
        tbl.push_back(mk(13,0,1,0,1,1,1, 32'h444,      32'h888,      32'h300,      32'h100,      1,0,1,1));
        tbl.push_back(cnt(mk(14,0,1,0,0,0,0, 32'h0,    32'h0,        32'h100,      32'h104,      1,1,0,0), 32'd3, 16'd4));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Memory wait at 0x40
        load_pc(32'h40);
        apply(mk(20,0,0,0,0,0,0, 32'h0, 32'h0, 32'h40, 32'h40, 1,0,0,0));
        apply(mk(21,0,0,0,0,0,0, 32'h0, 32'h0, 32'h40, 32'h40, 1,0,0,0));
        apply(mk(22,0,0,0,0,0,0, 32'h0, 32'h0, 32'h40, 32'h40, 1,0,0,0));
        apply(cnt(mk(23,0,1,0,0,0,0, 32'h0, 32'h0, 32'h40, 32'h44, 1,1,0,0), 32'd6, 16'd4));

        // DRAIN: branch while busy, trap overwrites, then memory returns
        apply(mk(30,0,0,0,0,1,0, 32'h0, 32'h80, 32'h44,  32'h44,  1,0,1,1));
        apply(mk(31,0,0,0,0,0,1, 32'h0, 32'h0,  32'h44,  32'h44,  1,0,1,1));
        apply(mk(32,0,1,0,0,0,0, 32'h0, 32'h0,  32'h44,  32'h100, 1,0,0,0));
        apply(cnt(mk(33,0,1,0,0,0,0, 32'h0, 32'h0, 32'h100, 32'h104, 1,1,0,0), 32'd8, 16'd6));

        // DRAIN: redirect arriving in the same cycle as imem_ready wins
        apply(mk(34,0,0,0,1,0,0, 32'h600, 32'h0, 32'h104, 32'h104, 1,0,1,0));
        apply(mk(35,0,1,0,1,0,0, 32'h700, 32'h0, 32'h104, 32'h700, 1,0,1,0));
        apply(cnt(mk(36,0,1,0,0,0,0, 32'h0, 32'h0, 32'h700, 32'h704, 1,1,0,0), 32'd9, 16'd8));

        // PC wrap, then reset while in DRAIN
        load_pc(32'hFFFF_FFFC);
        apply(mk(40,0,1,0,0,0,0, 32'h0, 32'h0,   32'hFFFF_FFFC, 32'h0, 1,1,0,0));
        apply(mk(41,0,1,0,0,0,0, 32'h0, 32'h0,   32'h0,         32'h4, 1,1,0,0));
        apply(mk(42,0,0,0,0,1,0, 32'h0, 32'h900, 32'h4,         32'h4, 1,0,1,1));
        apply(cnt(mk(43,1,0,0,0,0,1, 32'h0, 32'h0, 32'h0, 32'h0, 0,0,0,0), 32'd0, 16'd0));
        apply(mk(44,0,1,0,0,0,0, 32'h0, 32'h0,   32'h0,         32'h0, 0,0,0,0));
        apply(mk(45,0,1,0,0,0,0, 32'h0, 32'h0,   32'h0,         32'h4, 1,1,0,0));
        apply(cnt(mk(46,0,1,0,0,0,0, 32'h0, 32'h0, 32'h4, 32'h8, 1,1,0,0), 32'd0, 16'd0));

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
